// File: rtl/reservation_station.sv
// Reservation station: holds renamed ALU instructions until both operands are ready,
// snoops both CDBs, and issues the lowest-index ready entry once per cycle.
module reservation_station #(
    parameter int RS_SIZE     = 16,
    parameter int RS_IDX_W    = 4,
    parameter int ROB_TAG_W   = 4,
    parameter int INST_TYPE_W = 6,
    parameter int XLEN        = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear_in,
    input  logic                   en_in,
    input  logic [INST_TYPE_W-1:0] inst_type_in,
    input  logic [XLEN-1:0]        vj_in,
    input  logic [XLEN-1:0]        vk_in,
    input  logic [ROB_TAG_W-1:0]   qj_in,
    input  logic [ROB_TAG_W-1:0]   qk_in,
    input  logic [XLEN-1:0]        A_in,
    input  logic [ROB_TAG_W-1:0]   dest_in,
    input  logic [XLEN-1:0]        pc_in,
    output logic                   full_out,
    input  logic                   cdb_alu_en_in,
    input  logic [ROB_TAG_W-1:0]   cdb_alu_tag_in,
    input  logic [XLEN-1:0]        cdb_alu_val_in,
    input  logic                   cdb_lsb_en_in,
    input  logic [ROB_TAG_W-1:0]   cdb_lsb_tag_in,
    input  logic [XLEN-1:0]        cdb_lsb_val_in,
    output logic                   alu_en_out,
    output logic [INST_TYPE_W-1:0] alu_inst_type_out,
    output logic [XLEN-1:0]        alu_vj_out,
    output logic [XLEN-1:0]        alu_vk_out,
    output logic [XLEN-1:0]        alu_A_out,
    output logic [XLEN-1:0]        alu_pc_out,
    output logic [ROB_TAG_W-1:0]   alu_dest_out
);

    logic [RS_SIZE-1:0]     r_busy;
    logic [INST_TYPE_W-1:0] r_type [RS_SIZE];
    logic [XLEN-1:0]        r_vj   [RS_SIZE];
    logic [XLEN-1:0]        r_vk   [RS_SIZE];
    logic [XLEN-1:0]        r_a    [RS_SIZE];
    logic [XLEN-1:0]        r_pc   [RS_SIZE];
    logic [ROB_TAG_W-1:0]   r_qj   [RS_SIZE];
    logic [ROB_TAG_W-1:0]   r_qk   [RS_SIZE];
    logic [ROB_TAG_W-1:0]   r_dest [RS_SIZE];

    logic                   r_alu_en;
    logic [INST_TYPE_W-1:0] r_alu_type;
    logic [XLEN-1:0]        r_alu_vj, r_alu_vk, r_alu_a, r_alu_pc;
    logic [ROB_TAG_W-1:0]   r_alu_dest;

    logic                   w_free_found, w_issue_found;
    logic [RS_IDX_W-1:0]    w_free_idx, w_issue_idx;
    logic [RS_IDX_W:0]      w_count;
    logic [XLEN-1:0]        w_new_vj, w_new_vk;
    logic [ROB_TAG_W-1:0]   w_new_qj, w_new_qk;

    function automatic logic f_hit(input logic [ROB_TAG_W-1:0] q, input logic bus_en,
                                   input logic [ROB_TAG_W-1:0] bus_tag);
        return bus_en && (q != '0) && (q == bus_tag);
    endfunction

    // Scan downward so the lowest index wins both the free and ready searches.
    always_comb begin
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_issue_found = 1'b0;
        w_issue_idx   = '0;
        w_count       = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_IDX_W'(i);
            end
            if (r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0)) begin
                w_issue_found = 1'b1;
                w_issue_idx   = RS_IDX_W'(i);
            end
            w_count = w_count + (RS_IDX_W + 1)'(r_busy[i]);
        end
    end

    // Same-cycle capture for incoming operands; the ALU bus is applied last so it wins.
    always_comb begin
        w_new_vj = vj_in;
        w_new_qj = qj_in;
        w_new_vk = vk_in;
        w_new_qk = qk_in;
        if (f_hit(qj_in, cdb_lsb_en_in, cdb_lsb_tag_in)) begin w_new_vj = cdb_lsb_val_in; w_new_qj = '0; end
        if (f_hit(qj_in, cdb_alu_en_in, cdb_alu_tag_in)) begin w_new_vj = cdb_alu_val_in; w_new_qj = '0; end
        if (f_hit(qk_in, cdb_lsb_en_in, cdb_lsb_tag_in)) begin w_new_vk = cdb_lsb_val_in; w_new_qk = '0; end
        if (f_hit(qk_in, cdb_alu_en_in, cdb_alu_tag_in)) begin w_new_vk = cdb_alu_val_in; w_new_qk = '0; end
    end

    // One slot of headroom covers the dispatch already in flight when this rises.
    assign full_out = (w_count >= (RS_IDX_W + 1)'(RS_SIZE - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy     <= '0;
            r_alu_en   <= 1'b0;
            r_alu_type <= '0;
            r_alu_vj   <= '0;
            r_alu_vk   <= '0;
            r_alu_a    <= '0;
            r_alu_pc   <= '0;
            r_alu_dest <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy   <= '0;
                r_alu_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i]) begin
                        if (f_hit(r_qj[i], cdb_lsb_en_in, cdb_lsb_tag_in)) begin r_vj[i] <= cdb_lsb_val_in; r_qj[i] <= '0; end
                        if (f_hit(r_qj[i], cdb_alu_en_in, cdb_alu_tag_in)) begin r_vj[i] <= cdb_alu_val_in; r_qj[i] <= '0; end
                        if (f_hit(r_qk[i], cdb_lsb_en_in, cdb_lsb_tag_in)) begin r_vk[i] <= cdb_lsb_val_in; r_qk[i] <= '0; end
                        if (f_hit(r_qk[i], cdb_alu_en_in, cdb_alu_tag_in)) begin r_vk[i] <= cdb_alu_val_in; r_qk[i] <= '0; end
                    end
                end
                r_alu_en <= w_issue_found;
                if (w_issue_found) begin
                    r_alu_type            <= r_type[w_issue_idx];
                    r_alu_vj              <= r_vj[w_issue_idx];
                    r_alu_vk              <= r_vk[w_issue_idx];
                    r_alu_a               <= r_a[w_issue_idx];
                    r_alu_pc              <= r_pc[w_issue_idx];
                    r_alu_dest            <= r_dest[w_issue_idx];
                    r_busy[w_issue_idx]   <= 1'b0;
                end
                // Free slot comes from cycle-start busy bits, so an issuing slot is never reused here.
                if (en_in && w_free_found) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_type[w_free_idx] <= inst_type_in;
                    r_vj[w_free_idx]   <= w_new_vj;
                    r_qj[w_free_idx]   <= w_new_qj;
                    r_vk[w_free_idx]   <= w_new_vk;
                    r_qk[w_free_idx]   <= w_new_qk;
                    r_a[w_free_idx]    <= A_in;
                    r_pc[w_free_idx]   <= pc_in;
                    r_dest[w_free_idx] <= dest_in;
                end
            end
        end
    end

    assign alu_en_out        = r_alu_en;
    assign alu_inst_type_out = r_alu_type;
    assign alu_vj_out        = r_alu_vj;
    assign alu_vk_out        = r_alu_vk;
    assign alu_A_out         = r_alu_a;
    assign alu_pc_out        = r_alu_pc;
    assign alu_dest_out      = r_alu_dest;

endmodule
